// File: rtl/stl2sts_pkg.sv
// Shared constants and state encoding for the 32-to-16 Avalon-ST width downsizer.
package stl2sts_pkg;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SYM_W = 8;

    localparam int IN_EMPTY_W  = $clog2(IN_W / SYM_W);
    localparam int OUT_EMPTY_W = $clog2(OUT_W / SYM_W);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HI    = 2'd1;
    localparam logic [1:0] LO    = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = EMPTY,
        ST_HI    = HI,
        ST_LO    = LO
    } state_t;

    // An EOP word with two or three empty bytes carries data in its upper half only.
    function automatic logic upper_only(input logic eop, input logic [IN_EMPTY_W-1:0] emp);
        return eop & emp[1];
    endfunction

endpackage

// File: rtl/stl2sts_if.sv
// Avalon-ST bus bundle; the master drives the beat, the slave drives ready.
interface stl2sts_if
    import stl2sts_pkg::*;
#(
    parameter int DATA_W  = IN_W,
    parameter int EMPTY_W = IN_EMPTY_W
) ();

    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               ready;
    logic [EMPTY_W-1:0] empty;
    logic               startofpacket;
    logic               endofpacket;

    modport master (
        output data, valid, empty, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, empty, startofpacket, endofpacket,
        output ready
    );

endinterface

// File: rtl/stl2sts.sv
// Splits each accepted 32-bit packet word into two 16-bit beats, upper half first.
// Beats arriving outside a packet without SOP are discarded and flagged on drop_pulse.
module stl2sts
    import stl2sts_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    stl2sts_if.slave  data_in,
    stl2sts_if.master data_out,
    output logic      drop_pulse
);

    state_t                state;
    state_t                state_nxt;
    logic [IN_W-1:0]       hold;
    logic [IN_W-1:0]       hold_nxt;
    logic                  sop_f;
    logic                  sop_nxt;
    logic                  eop_f;
    logic                  eop_nxt;
    logic [IN_EMPTY_W-1:0] emp_f;
    logic [IN_EMPTY_W-1:0] emp_nxt;
    logic                  in_pkt;
    logic                  in_pkt_nxt;
    logic                  accept;
    logic                  load;
    logic                  drop;
    logic                  out_eop_nxt;

    // The sink may refill the holding register in the same cycle its last half leaves.
    assign data_in.ready = !rst &&
                           ((state == ST_EMPTY) ||
                            (state == ST_LO && data_out.ready) ||
                            (state == ST_HI && data_out.ready && upper_only(eop_f, emp_f)));

    assign accept = data_in.valid & data_in.ready;
    assign load   = accept & (in_pkt | data_in.startofpacket);
    assign drop   = accept & ~load;

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold;
        sop_nxt    = sop_f;
        eop_nxt    = eop_f;
        emp_nxt    = emp_f;
        in_pkt_nxt = in_pkt;

        case (state)
            ST_HI: begin
                if (data_out.ready) begin
                    state_nxt = upper_only(eop_f, emp_f) ? ST_EMPTY : ST_LO;
                end
            end
            ST_LO: begin
                if (data_out.ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            if (data_in.endofpacket) begin
                in_pkt_nxt = 1'b0;
            end else if (data_in.startofpacket) begin
                in_pkt_nxt = 1'b1;
            end
        end

        if (load) begin
            state_nxt = ST_HI;
            hold_nxt  = data_in.data;
            sop_nxt   = data_in.startofpacket;
            eop_nxt   = data_in.endofpacket;
            emp_nxt   = data_in.empty;
        end

        out_eop_nxt = ((state_nxt == ST_LO) & eop_nxt) |
                      ((state_nxt == ST_HI) & upper_only(eop_nxt, emp_nxt));
    end

    // Source outputs are registered from the next state so they never follow sink inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= ST_EMPTY;
            hold                   <= '0;
            sop_f                  <= 1'b0;
            eop_f                  <= 1'b0;
            emp_f                  <= '0;
            in_pkt                 <= 1'b0;
            data_out.valid         <= 1'b0;
            data_out.data          <= '0;
            data_out.startofpacket <= 1'b0;
            data_out.endofpacket   <= 1'b0;
            data_out.empty         <= '0;
            drop_pulse             <= 1'b0;
        end else begin
            state                  <= state_nxt;
            hold                   <= hold_nxt;
            sop_f                  <= sop_nxt;
            eop_f                  <= eop_nxt;
            emp_f                  <= emp_nxt;
            in_pkt                 <= in_pkt_nxt;
            data_out.valid         <= (state_nxt != ST_EMPTY);
            data_out.data          <= (state_nxt == ST_HI) ? hold_nxt[IN_W-1:OUT_W] :
                                      (state_nxt == ST_LO) ? hold_nxt[OUT_W-1:0] : '0;
            data_out.startofpacket <= (state_nxt == ST_HI) & sop_nxt;
            data_out.endofpacket   <= out_eop_nxt;
            data_out.empty         <= out_eop_nxt & emp_nxt[0];
            drop_pulse             <= drop;
        end
    end

endmodule

// File: tb/tb_stl2sts.sv
// Directed bench for stl2sts: a queue-of-halves model checked every cycle plus literal pins.
module tb_stl2sts;
    import stl2sts_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic drop_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    stl2sts_if #(.DATA_W(IN_W),  .EMPTY_W(IN_EMPTY_W))  in_bus ();
    stl2sts_if #(.DATA_W(OUT_W), .EMPTY_W(OUT_EMPTY_W)) out_bus ();

    stl2sts dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (in_bus.slave),
        .data_out   (out_bus.master),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        emp;
    } half_t;

    half_t exp_q[$];
    bit    m_in_pkt = 1'b0;
    bit    m_drop   = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The sink can take a word when no halves are pending, or the only one leaves now.
    function automatic bit m_ready();
        return !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_bus.ready));
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit    acc;
        bit    short_word;
        half_t h;
        if (rst) begin
            exp_q.delete();
            m_in_pkt = 1'b0;
            m_drop   = 1'b0;
        end else begin
            acc = in_bus.valid && m_ready();
            if (exp_q.size() > 0 && out_bus.ready) void'(exp_q.pop_front());
            m_drop = 1'b0;
            if (acc) begin
                if (m_in_pkt || in_bus.startofpacket) begin
                    short_word = in_bus.endofpacket && in_bus.empty >= 2'd2;
                    h.d   = in_bus.data[31:16];
                    h.sop = in_bus.startofpacket;
                    h.eop = short_word;
                    h.emp = short_word && in_bus.empty == 2'd3;
                    exp_q.push_back(h);
                    if (!short_word) begin
                        h.d   = in_bus.data[15:0];
                        h.sop = 1'b0;
                        h.eop = in_bus.endofpacket;
                        h.emp = in_bus.endofpacket && in_bus.empty == 2'd1;
                        exp_q.push_back(h);
                    end
                end else begin
                    m_drop = 1'b1;
                end
                if (in_bus.endofpacket) m_in_pkt = 1'b0;
                else if (in_bus.startofpacket) m_in_pkt = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        half_t e;
        bit    ev;
        ev = exp_q.size() > 0;
        if (ev) e = exp_q[0];
        else begin
            e.d = 16'h0; e.sop = 1'b0; e.eop = 1'b0; e.emp = 1'b0;
        end
        check_output("model_valid", 32'(out_bus.valid), 32'(ev));
        check_output("model_data",  32'(out_bus.data), 32'(e.d));
        check_output("model_sop",   32'(out_bus.startofpacket), 32'(e.sop));
        check_output("model_eop",   32'(out_bus.endofpacket), 32'(e.eop));
        check_output("model_empty", 32'(out_bus.empty), 32'(e.emp));
        check_output("model_ready", 32'(in_bus.ready), 32'(m_ready()));
        check_output("model_drop",  32'(drop_pulse), 32'(m_drop));
    end

    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic s,
                                  input logic e, input logic [1:0] em, input logic ordy);
        @(posedge clk);
        #1;
        in_bus.valid         = v;
        in_bus.data          = d;
        in_bus.startofpacket = s;
        in_bus.endofpacket   = e;
        in_bus.empty         = em;
        out_bus.ready        = ordy;
        @(negedge clk);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        in_bus.valid         = 1'b0;
        in_bus.data          = '0;
        in_bus.startofpacket = 1'b0;
        in_bus.endofpacket   = 1'b0;
        in_bus.empty         = '0;
        out_bus.ready        = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("reset_ready", 32'(in_bus.ready), 32'd1);
        check_output("reset_valid", 32'(out_bus.valid), 32'd0);
        check_output("reset_data",  32'(out_bus.data), 32'd0);
        check_output("reset_drop",  32'(drop_pulse), 32'd0);

        // Two-word packet streamed with the source always ready
        apply_stimulus(1'b1, 32'h11112222, 1'b1, 1'b0, 2'd0, 1'b1);
        check_output("p1_ready0", 32'(in_bus.ready), 32'd1);
        apply_stimulus(1'b1, 32'h33334444, 1'b0, 1'b1, 2'd0, 1'b1);
        check_output("p1_data0", 32'(out_bus.data), 32'h1111);
        check_output("p1_sop0",  32'(out_bus.startofpacket), 32'd1);
        check_output("p1_ready1", 32'(in_bus.ready), 32'd0);
        apply_stimulus(1'b1, 32'h33334444, 1'b0, 1'b1, 2'd0, 1'b1);
        check_output("p1_data1", 32'(out_bus.data), 32'h2222);
        check_output("p1_ready2", 32'(in_bus.ready), 32'd1);
        idle();
        check_output("p1_data2", 32'(out_bus.data), 32'h3333);
        check_output("p1_ready3", 32'(in_bus.ready), 32'd0);
        idle();
        check_output("p1_data3", 32'(out_bus.data), 32'h4444);
        check_output("p1_eop3",  32'(out_bus.endofpacket), 32'd1);
        check_output("p1_empty3", 32'(out_bus.empty), 32'd0);
        idle();
        check_output("p1_idle_valid", 32'(out_bus.valid), 32'd0);

        // Upper-half-only EOP word lets the next word in during its single beat
        apply_stimulus(1'b1, 32'h01020304, 1'b1, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b1, 32'hAAAA5555, 1'b0, 1'b1, 2'd2, 1'b1);
        apply_stimulus(1'b1, 32'hAAAA5555, 1'b0, 1'b1, 2'd2, 1'b1);
        check_output("p2_lo", 32'(out_bus.data), 32'h0304);
        apply_stimulus(1'b1, 32'h55556666, 1'b1, 1'b1, 2'd0, 1'b1);
        check_output("p2_short_data",  32'(out_bus.data), 32'hAAAA);
        check_output("p2_short_eop",   32'(out_bus.endofpacket), 32'd1);
        check_output("p2_short_empty", 32'(out_bus.empty), 32'd0);
        check_output("p2_short_ready", 32'(in_bus.ready), 32'd1);
        idle();
        check_output("p2_next_data", 32'(out_bus.data), 32'h5555);
        check_output("p2_next_sop",  32'(out_bus.startofpacket), 32'd1);
        idle();
        idle();

        // Single-word packet with one empty byte
        apply_stimulus(1'b1, 32'h77778888, 1'b1, 1'b1, 2'd1, 1'b1);
        idle();
        check_output("p3_hi_eop", 32'(out_bus.endofpacket), 32'd0);
        idle();
        check_output("p3_lo_data",  32'(out_bus.data), 32'h8888);
        check_output("p3_lo_eop",   32'(out_bus.endofpacket), 32'd1);
        check_output("p3_lo_empty", 32'(out_bus.empty), 32'd1);
        idle();

        // Backpressure during the upper half of 0xDEADBEEF
        apply_stimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 2'd0, (i == 2) ? 1'b1 : 1'b0);
            check_output("p4_hold_data",  32'(out_bus.data), 32'hDEAD);
            check_output("p4_hold_ready", 32'(in_bus.ready), 32'd0);
        end
        apply_stimulus(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 2'd0, 1'b1);
        check_output("p4_lo_data", 32'(out_bus.data), 32'hBEEF);
        idle();
        check_output("p4_next_data", 32'(out_bus.data), 32'hCAFE);
        idle();
        idle();

        // Beat without SOP while idle is swallowed
        apply_stimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 2'd0, 1'b1);
        check_output("p5_ready", 32'(in_bus.ready), 32'd1);
        idle();
        check_output("p5_drop",  32'(drop_pulse), 32'd1);
        check_output("p5_valid", 32'(out_bus.valid), 32'd0);
        idle();
        check_output("p5_drop_end", 32'(drop_pulse), 32'd0);

        // Reset in the lower half of a three-word packet
        apply_stimulus(1'b1, 32'hA1A1B1B1, 1'b1, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b1, 32'hC1C1D1D1, 1'b0, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b1, 32'hC1C1D1D1, 1'b0, 1'b0, 2'd0, 1'b1);
        check_output("p6_lo_data", 32'(out_bus.data), 32'hB1B1);
        #2 rst = 1'b1;
        #1;
        check_output("p6_rst_valid", 32'(out_bus.valid), 32'd0);
        check_output("p6_rst_ready", 32'(in_bus.ready), 32'd0);
        check_output("p6_rst_data",  32'(out_bus.data), 32'd0);
        in_bus.valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(1'b1, 32'h0000FFFF, 1'b0, 1'b0, 2'd0, 1'b1);
        check_output("p6_after_ready", 32'(in_bus.ready), 32'd1);
        idle();
        check_output("p6_after_drop",  32'(drop_pulse), 32'd1);
        check_output("p6_after_valid", 32'(out_bus.valid), 32'd0);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
